lsf_segment_collector: RTL
==========================

Name: lsf_segment_collector

Overview:
- Sits directly downstream of the per-station LSF segment finders (inner/middle/outer) and upstream of the pT calculator.
- Tracks each sector-logic candidate (SLC) that is opened and collects the one segment per station tagged with that SLC id.
- Emits one combined record per SLC, in SLC arrival order, once all three stations have reported or a programmable timeout expires.

Parameters:
SEG_W, SF2PTCALC_LEN, width of one station segment word
ID_W, 4, SLC id width
NSLOT, 4, number of concurrently open SLC slots (power of 2)
TMO_W, 10, timeout counter width
CNT_W, 16, monitor counter width

Ports:
clock  in  1  main TP clock, nominally 200 MHz
reset  in  1  asynchronous, active-high reset
slc_vld  in  1  open a slot for slc_id
slc_id  in  ID_W  SLC identifier
seg_i_vld / seg_m_vld / seg_o_vld  in  1 each  station segment valid
seg_i_id / seg_m_id / seg_o_id  in  ID_W each  SLC id of the segment
seg_i / seg_m / seg_o  in  SEG_W each  segment data
timeout_count  in  TMO_W  cycles from slot open to forced retire; 0 disables timeout
slc_full  out  1  all NSLOT slots occupied
out_vld  out  1  combined record valid
out_ready  in  1  pT-calc accepts record
out_id  out  ID_W  SLC id of record
out_seg_i / out_seg_m / out_seg_o  out  SEG_W each  collected segments (0 where missing)
out_mask  out  3  {outer,middle,inner} segment present
out_timeout  out  1  record retired by timeout
drop_slc_cnt / orphan_seg_cnt / timeout_cnt  out  CNT_W each  saturating monitor counters

Behaviour:
- Reset: all slots empty; head = tail = 0; slc_full = 0; out_vld = 0; all out_* data = 0; all counters = 0. Reset mid-operation discards all open slots immediately.
- Slots form a circular queue of NSLOT entries. Each entry holds: id, 3 segment registers, mask, timer, flag.
- Allocate on slc_vld, at tail. The slot becomes open the next cycle with mask = 000 and timer = 0. Tail wraps modulo NSLOT.
- slc_full = (occupancy == NSLOT), evaluated on registered state.
- slc_vld while full: SLC dropped, drop_slc_cnt += 1. A pop in the same cycle does not free space for that SLC.
- slc_vld with an id equal to any open slot's id: dropped, drop_slc_cnt += 1.
- Segment match: seg_x_vld compares seg_x_id against all open slots.
  - On a hit, store data and set the mask bit (visible next cycle).
  - No hit, including a slot being allocated in the same cycle: discard, orphan_seg_cnt += 1.
  - Station bit already set: discard, orphan_seg_cnt += 1; first segment is kept.
  - Three stations may match in the same cycle, to the same or different slots; each is handled independently and all are counted.
- Timer: increments each cycle while the slot is open and mask != 111, saturating at all-ones.
  - When timeout_count != 0 and timer == timeout_count, the slot is flagged timed-out.
  - A segment arriving in the flag cycle is still stored.
- Head retire condition: mask == 111 or timed-out.
  - out_vld and out_* are driven combinationally from head slot registers, so out_vld rises the cycle after the completing write or the timeout flag.
  - out_timeout = 1 only when mask != 111.
- Handshake: pop on out_vld & out_ready. Head advances, the slot is freed the next cycle, and the next head may present in that next cycle (back-to-back records allowed).
- Output order is strictly allocation order. A younger complete slot waits behind an incomplete head.
- out_* is held stable while out_vld & !out_ready.
- timeout_cnt += 1 per popped record with out_timeout = 1.
- All counters saturate at 2^CNT_W - 1.
- Missing segments are output as all-zero.
- Latency, complete case: last segment accepted at cycle N -> out_vld at N+1, provided the slot is head.

Test Plan:
- timeout_count = 100, slc id 3 at c0; seg_i c5, seg_m c9, seg_o c12 (id 3); out_ready = 1 -> out_vld only at c13, out_id = 3, out_mask = 111, out_timeout = 0, segment data equals inputs.
- timeout_count = 20, slc id 5 at c0; only seg_i (id 5) at c3 -> out_vld at c21, out_mask = 001, out_seg_m = out_seg_o = 0, out_timeout = 1; timeout_cnt = 1 after pop.
- SLCs with ids 0,1,2,3 on c0–c3, none popped; id 4 at c4 -> slc_full = 1 from c4, id 4 dropped, drop_slc_cnt = 1; a repeat of id 2 also increments the count.
- SLCs id 1 then id 2; id 2 completes at c6, id 1 completes at c10; out_ready = 1 -> id 1 at c11, id 2 at c12, consecutive cycles.
- Complete record with out_ready = 0 for 5 cycles -> out_vld and data stable for all 5 cycles; single pop when out_ready rises.
- seg_m for unopened id 7 -> orphan_seg_cnt = 1. Duplicate seg_i to an open slot -> orphan_seg_cnt = 2, first data retained. Then reset asserted with 2 slots open -> out_vld = 0, slc_full = 0 and counters 0 immediately; a new SLC allocates at slot 0.

Source files
------------

// File: rtl/lsf_segment_collector.sv
// LSF segment collector: gathers the inner/middle/outer segments tagged with
// each sector-logic candidate id and hands one combined record per candidate
// to the pT calculator, strictly in candidate arrival order.
//
// Output handshake: a record is offered while out_vld is high and is consumed
// on any clock edge where out_vld && out_ready. While out_vld && !out_ready
// every out_* field holds its value. out_vld never drops without a transfer.
module lsf_segment_collector #(
    parameter int SEG_W = 32,   // segment-finder to pT-calc word length
    parameter int ID_W  = 4,
    parameter int NSLOT = 4,
    parameter int TMO_W = 10,
    parameter int CNT_W = 16
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             slc_vld,
    input  logic [ID_W-1:0]  slc_id,
    input  logic             seg_i_vld,
    input  logic             seg_m_vld,
    input  logic             seg_o_vld,
    input  logic [ID_W-1:0]  seg_i_id,
    input  logic [ID_W-1:0]  seg_m_id,
    input  logic [ID_W-1:0]  seg_o_id,
    input  logic [SEG_W-1:0] seg_i,
    input  logic [SEG_W-1:0] seg_m,
    input  logic [SEG_W-1:0] seg_o,
    input  logic [TMO_W-1:0] timeout_count,
    output logic             slc_full,
    output logic             out_vld,
    input  logic             out_ready,
    output logic [ID_W-1:0]  out_id,
    output logic [SEG_W-1:0] out_seg_i,
    output logic [SEG_W-1:0] out_seg_m,
    output logic [SEG_W-1:0] out_seg_o,
    output logic [2:0]       out_mask,
    output logic             out_timeout,
    output logic [CNT_W-1:0] drop_slc_cnt,
    output logic [CNT_W-1:0] orphan_seg_cnt,
    output logic [CNT_W-1:0] timeout_cnt
);

    localparam int PTR_W = (NSLOT > 1) ? $clog2(NSLOT) : 1;
    localparam int OCC_W = $clog2(NSLOT + 1);

    // Slot storage; station index 0 = inner, 1 = middle, 2 = outer
    logic [ID_W-1:0]  r_id    [NSLOT];
    logic [SEG_W-1:0] r_seg   [NSLOT][3];
    logic [2:0]       r_mask  [NSLOT];
    logic [TMO_W-1:0] r_timer [NSLOT];
    logic [NSLOT-1:0] r_open;
    logic [NSLOT-1:0] r_tmo;
    logic [PTR_W-1:0] r_head;
    logic [PTR_W-1:0] r_tail;
    logic [OCC_W-1:0] r_occ;
    logic [CNT_W-1:0] r_drop_cnt;
    logic [CNT_W-1:0] r_orph_cnt;
    logic [CNT_W-1:0] r_tmo_cnt;

    logic [2:0]       w_seg_vld;
    logic [ID_W-1:0]  w_seg_id  [3];
    logic [SEG_W-1:0] w_seg_dat [3];
    logic [NSLOT-1:0] w_store   [3];
    logic [2:0]       w_orphan;
    logic [1:0]       w_orph_n;
    logic             w_dup;
    logic             w_full;
    logic             w_alloc;
    logic             w_drop;
    logic             w_pop;
    logic             w_out_vld;
    logic [NSLOT-1:0] w_tinc;
    logic [NSLOT-1:0] w_tmo_hit;

    assign w_seg_vld    = {seg_o_vld, seg_m_vld, seg_i_vld};
    assign w_seg_id[0]  = seg_i_id;
    assign w_seg_id[1]  = seg_m_id;
    assign w_seg_id[2]  = seg_o_id;
    assign w_seg_dat[0] = seg_i;
    assign w_seg_dat[1] = seg_m;
    assign w_seg_dat[2] = seg_o;

    function automatic logic [CNT_W-1:0] sat_add(input logic [CNT_W-1:0] c,
                                                 input logic [1:0] n);
        logic [CNT_W:0] s;
        s = {1'b0, c} + {{(CNT_W-1){1'b0}}, n};
        return s[CNT_W] ? {CNT_W{1'b1}} : s[CNT_W-1:0];
    endfunction

    // Segment matching: a station word lands only in an open, not-yet-filled,
    // not-timed-out slot; everything else is counted as an orphan
    always_comb begin
        for (int s = 0; s < 3; s++) begin
            w_store[s] = '0;
        end
        w_orphan = '0;
        for (int s = 0; s < 3; s++) begin
            for (int k = 0; k < NSLOT; k++) begin
                w_store[s][k] = w_seg_vld[s] & r_open[k] & (r_id[k] == w_seg_id[s])
                                & ~r_mask[k][s] & ~r_tmo[k];
            end
            w_orphan[s] = w_seg_vld[s] & ~(|w_store[s]);
        end
        w_orph_n = {1'b0, w_orphan[0]} + {1'b0, w_orphan[1]} + {1'b0, w_orphan[2]};
    end

    // Allocation decision and per-slot timer control
    always_comb begin
        w_dup     = 1'b0;
        w_tinc    = '0;
        w_tmo_hit = '0;
        for (int k = 0; k < NSLOT; k++) begin
            if (r_open[k] && r_id[k] == slc_id) w_dup = 1'b1;
            w_tinc[k] = r_open[k] & (r_mask[k] != 3'b111) & (r_timer[k] != {TMO_W{1'b1}});
            w_tmo_hit[k] = w_tinc[k] & (timeout_count != '0)
                           & ((r_timer[k] + TMO_W'(1)) == timeout_count);
        end
        w_full  = (r_occ == OCC_W'(NSLOT));
        w_alloc = slc_vld & ~w_full & ~w_dup;
        w_drop  = slc_vld & ~w_alloc;
    end

    // Head presentation: record data gated to zero when nothing is offered
    always_comb begin
        w_out_vld   = r_open[r_head] & ((r_mask[r_head] == 3'b111) | r_tmo[r_head]);
        w_pop       = w_out_vld & out_ready;
        out_vld     = w_out_vld;
        out_id      = w_out_vld ? r_id[r_head] : '0;
        out_seg_i   = w_out_vld ? r_seg[r_head][0] : '0;
        out_seg_m   = w_out_vld ? r_seg[r_head][1] : '0;
        out_seg_o   = w_out_vld ? r_seg[r_head][2] : '0;
        out_mask    = w_out_vld ? r_mask[r_head] : '0;
        out_timeout = w_out_vld & (r_mask[r_head] != 3'b111);
    end

    assign slc_full       = w_full;
    assign drop_slc_cnt   = r_drop_cnt;
    assign orphan_seg_cnt = r_orph_cnt;
    assign timeout_cnt    = r_tmo_cnt;

    // Slot contents: timer/flag, segment capture, free on pop, init on alloc
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            for (int k = 0; k < NSLOT; k++) begin
                r_id[k]    <= '0;
                r_mask[k]  <= '0;
                r_timer[k] <= '0;
                for (int s = 0; s < 3; s++) begin
                    r_seg[k][s] <= '0;
                end
            end
            r_open <= '0;
            r_tmo  <= '0;
        end else begin
            for (int k = 0; k < NSLOT; k++) begin
                if (w_tinc[k])    r_timer[k] <= r_timer[k] + TMO_W'(1);
                if (w_tmo_hit[k]) r_tmo[k]   <= 1'b1;
                for (int s = 0; s < 3; s++) begin
                    if (w_store[s][k]) begin
                        r_seg[k][s]  <= w_seg_dat[s];
                        r_mask[k][s] <= 1'b1;
                    end
                end
                if (w_pop && r_head == PTR_W'(k)) begin
                    r_open[k] <= 1'b0;
                    r_tmo[k]  <= 1'b0;
                    r_mask[k] <= '0;
                end
                if (w_alloc && r_tail == PTR_W'(k)) begin
                    r_open[k]  <= 1'b1;
                    r_id[k]    <= slc_id;
                    r_mask[k]  <= '0;
                    r_timer[k] <= '0;
                    r_tmo[k]   <= 1'b0;
                    for (int s = 0; s < 3; s++) begin
                        r_seg[k][s] <= '0;
                    end
                end
            end
        end
    end

    // Queue pointers and occupancy; pointers wrap naturally (NSLOT is 2^n)
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_head <= '0;
            r_tail <= '0;
            r_occ  <= '0;
        end else begin
            if (w_pop)   r_head <= r_head + PTR_W'(1);
            if (w_alloc) r_tail <= r_tail + PTR_W'(1);
            case ({w_alloc, w_pop})
                2'b10:   r_occ <= r_occ + OCC_W'(1);
                2'b01:   r_occ <= r_occ - OCC_W'(1);
                default: r_occ <= r_occ;
            endcase
        end
    end

    // Saturating monitor counters
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_drop_cnt <= '0;
            r_orph_cnt <= '0;
            r_tmo_cnt  <= '0;
        end else begin
            r_drop_cnt <= sat_add(r_drop_cnt, {1'b0, w_drop});
            r_orph_cnt <= sat_add(r_orph_cnt, w_orph_n);
            r_tmo_cnt  <= sat_add(r_tmo_cnt, {1'b0, w_pop & out_timeout});
        end
    end

endmodule
